pipeline_hazard_sequencer: RTL and testbench
============================================

// Module: pipeline_hazard_sequencer
// PURPOSE
// - Central stall/flush/forward controller for the 3-stage pipeline (IF -> DE -> MW).
// - Drives Stall_MW into the MW control pipeline register, plus the PC/IF-DE stall and flush controls.
// - Generates operand-forwarding selects for DE.
// - Sequences multi-cycle data-memory waits, taken-branch flushes, interrupt entry and mret return.
// PARAMETERS
// - MEM_TIMEOUT  default 16  max cycles in MEM_WAIT before mem_fault; range 2..255.
// - TO_W         default 8    width of the wait counter; must satisfy 2**TO_W > MEM_TIMEOUT.
// PORTS
// clk          in   1   clock, rising edge
// rst          in   1   synchronous, active-high reset
// rs1DE        in   5   DE-stage source register 1
// rs2DE        in   5   DE-stage source register 2
// rdMW         in   5   MW-stage destination register
// reg_wrMW     in   1   MW-stage instruction writes the register file
// wb_selMW     in   2   MW writeback select (pkg WB_ALU/WB_MEM/WB_PC4/WB_CSR)
// br_takenDE   in   1   DE-stage branch/jump resolved taken
// dmem_req     in   1   MW-stage load/store is accessing data memory this cycle
// dmem_ack     in   1   data memory completes the access this cycle
// irq_pending  in   1   enabled interrupt pending, level, from CSR file
// is_mretMW    in   1   mret in MW stage
// stall_pc     out  1   hold the PC
// stall_IFDE   out  1   hold the IF/DE register
// Stall_MW     out  1   hold the MW register
// flush_IFDE   out  1   load a NOP into IF/DE on the next edge
// flush_MW     out  1   load a bubble into MW (reg_wr=0, csr_wr=0) on the next edge
// fwd_a        out  2   rs1 operand select (pkg FWD_RF/FWD_ALU/FWD_WB)
// fwd_b        out  2   rs2 operand select
// trap_take    out  1   one-cycle pulse: CSR file saves mepc and redirects the PC to mtvec
// mem_fault    out  1   one-cycle pulse: memory timeout
// state_o      out  2   current FSM state, for debug
// BEHAVIOUR
// Reset
// - state = RUN, counter = 0, pending_flush = 0.
// - All stall, flush and pulse outputs are 0; fwd_a = fwd_b = FWD_RF.
// Forwarding (combinational)
// - A match requires reg_wrMW && rdMW != 0 && rdMW == rsX.
// - On a match: FWD_WB if wb_selMW is WB_MEM or WB_CSR, else FWD_ALU.
// - No match: FWD_RF. x0 is never forwarded.
// FSM RUN
// - dmem_req && !dmem_ack -> MEM_WAIT. Counter = 1. Stall all three stages in the same cycle (combinational).
// - else irq_pending -> TRAP_DRAIN.
// - else mret or taken branch -> flush_IFDE = 1.
//   - is_mretMW also asserts flush_MW.
// FSM MEM_WAIT
// - stall_pc, stall_IFDE and Stall_MW are all 1 until dmem_ack.
// - On dmem_ack: drop the stalls the same cycle, return to RUN, counter = 0.
// - counter == MEM_TIMEOUT without ack: pulse mem_fault, flush_MW, go to RUN.
// - br_takenDE while stalled: set pending_flush. Flush is never asserted during a stall.
// - pending_flush drives flush_IFDE on the first RUN cycle, then clears.
// FSM TRAP_DRAIN (1 cycle)
// - stall_pc = 1 and flush_IFDE = 1, so MW retires and no new instruction enters.
// - Next state: TRAP_ENTER.
// FSM TRAP_ENTER (1 cycle)
// - trap_take = 1, flush_IFDE = 1, flush_MW = 1.
// - Clears pending_flush. Next state: RUN.
// Precedence
// - Memory stall > interrupt > mret > branch.
// - irq_pending during MEM_WAIT is deferred until return to RUN.
// Reset mid-operation
// - Synchronous rst in any state returns to RUN with reset values on the next edge.
// - No pulse is emitted in the reset cycle.
// Latency
// - Stalls, flushes and forward selects are combinational from the inputs and the current state.
// - trap_take comes 2 cycles after irq_pending is sampled in RUN.
// STRUCTURE
// - hazard_pkg: typedef enum logic[1:0] {RUN, MEM_WAIT, TRAP_DRAIN, TRAP_ENTER} hz_state_t.
// - hazard_pkg: WB_* and FWD_* localparams, shared with the datapath muxes.
// - One sub-module, fwd_select: pure combinational match logic, instanced per operand.
// TESTING
// 1. rdMW=5, reg_wrMW=1, wb_selMW=WB_ALU, rs1DE=5, rs2DE=6 -> fwd_a=FWD_ALU, fwd_b=FWD_RF. Same with rdMW=0 -> both FWD_RF.
// 2. dmem_req=1 with ack after 3 cycles -> all stalls high for exactly 3 cycles, state_o=MEM_WAIT, released on the ack cycle.
// 3. dmem_req=1, never ack, MEM_TIMEOUT=16 -> mem_fault one-cycle pulse after 16 wait cycles, flush_MW=1, state RUN.
// 4. br_takenDE=1 during MEM_WAIT -> no flush while stalled; flush_IFDE=1 for exactly 1 cycle after ack.
// 5. irq_pending=1 in RUN -> TRAP_DRAIN (stall_pc, flush_IFDE), then trap_take pulse with flush_MW, then RUN. Simultaneous br_takenDE is dropped.
// 6. rst asserted in MEM_WAIT -> next cycle state RUN, all outputs at reset values.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_pkg                                                           |
// | Shared types and encodings for the pipeline hazard sequencer and    |
// | the datapath writeback / operand-forwarding muxes.                  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package hazard_pkg;

  // Sequencer state, also exported on state_o for debug
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    TRAP_DRAIN = 2'd2,
    TRAP_ENTER = 2'd3
  } hz_state_t;

  // MW writeback source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_CSR = 2'd3;

  // DE operand source select
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_ALU = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fwd_select                                                           |
// | Operand-forwarding match for one DE source register against the     |
// | MW destination. Pure combinational.                                  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd,
  input  logic       reg_wr,
  input  logic [1:0] wb_sel,
  output logic [1:0] fwd
);

  logic w_match;
  logic w_late_result;

  // x0 is hard-wired to zero, so a write to it must never be forwarded
  assign w_match       = reg_wr && (rd != 5'd0) && (rd == rs);
  // Load data and CSR read data only exist on the writeback path
  assign w_late_result = (wb_sel == WB_MEM) || (wb_sel == WB_CSR);

  // Pick the operand source for this register
  always_comb begin
    fwd = FWD_RF;
    if (w_match) begin
      fwd = w_late_result ? FWD_WB : FWD_ALU;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_hazard_sequencer                                            |
// | Stall / flush / forward controller for the IF -> DE -> MW pipeline. |
// | Sequences data-memory waits, branch and mret flushes, interrupt     |
// | entry, and produces DE operand-forwarding selects.                   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pipeline_hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1DE,
  input  logic [4:0] rs2DE,
  input  logic [4:0] rdMW,
  input  logic       reg_wrMW,
  input  logic [1:0] wb_selMW,
  input  logic       br_takenDE,
  input  logic       dmem_req,
  input  logic       dmem_ack,
  input  logic       irq_pending,
  input  logic       is_mretMW,
  output logic       stall_pc,
  output logic       stall_IFDE,
  output logic       Stall_MW,
  output logic       flush_IFDE,
  output logic       flush_MW,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       trap_take,
  output logic       mem_fault,
  output logic [1:0] state_o
);

  localparam logic [TO_W-1:0] c_timeout = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] c_one     = TO_W'(1);

  hz_state_t       r_state;
  logic [TO_W-1:0] r_count;
  logic            r_pend;

  logic       w_mem_stall;
  logic       w_timeout;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // A new access that does not complete this cycle freezes the pipe at once
  assign w_mem_stall = dmem_req && !dmem_ack;
  // The wait gives up only when the ack has still not arrived at the limit
  assign w_timeout   = (r_state == MEM_WAIT) && !dmem_ack && (r_count == c_timeout);

  fwd_select u_fwd_a (
    .rs     (rs1DE),
    .rd     (rdMW),
    .reg_wr (reg_wrMW),
    .wb_sel (wb_selMW),
    .fwd    (w_fwd_a)
  );

  fwd_select u_fwd_b (
    .rs     (rs2DE),
    .rd     (rdMW),
    .reg_wr (reg_wrMW),
    .wb_sel (wb_selMW),
    .fwd    (w_fwd_b)
  );

  // Sequencer state, wait counter and the branch flush deferred across a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_count <= '0;
      r_pend  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            r_state <= MEM_WAIT;
            r_count <= c_one;
            // The branch in DE is held by the stall; remember to kill its shadow
            if (br_takenDE) begin
              r_pend <= 1'b1;
            end
          end else begin
            // Any deferred flush is consumed (or superseded by the trap) here
            r_pend <= 1'b0;
            if (irq_pending) begin
              r_state <= TRAP_DRAIN;
            end
          end
        end
        MEM_WAIT: begin
          if (br_takenDE) begin
            r_pend <= 1'b1;
          end
          if (dmem_ack || w_timeout) begin
            r_state <= RUN;
            r_count <= '0;
          end else begin
            r_count <= r_count + c_one;
          end
        end
        TRAP_DRAIN: begin
          r_state <= TRAP_ENTER;
        end
        TRAP_ENTER: begin
          // The trap redirect discards whatever the deferred flush targeted
          r_pend  <= 1'b0;
          r_state <= RUN;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  // Pipeline controls decoded from the current state and live inputs; all quiet in reset
  always_comb begin
    stall_pc   = 1'b0;
    stall_IFDE = 1'b0;
    Stall_MW   = 1'b0;
    flush_IFDE = 1'b0;
    flush_MW   = 1'b0;
    trap_take  = 1'b0;
    mem_fault  = 1'b0;
    fwd_a      = FWD_RF;
    fwd_b      = FWD_RF;
    if (!rst) begin
      fwd_a = w_fwd_a;
      fwd_b = w_fwd_b;
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            stall_pc   = 1'b1;
            stall_IFDE = 1'b1;
            Stall_MW   = 1'b1;
          end else if (!irq_pending) begin
            // A pending interrupt outranks mret and branch flushes
            flush_IFDE = is_mretMW || br_takenDE || r_pend;
            flush_MW   = is_mretMW;
          end
        end
        MEM_WAIT: begin
          if (w_timeout) begin
            // Abandon the access: bubble the faulting instruction out of MW
            mem_fault = 1'b1;
            flush_MW  = 1'b1;
          end else if (!dmem_ack) begin
            stall_pc   = 1'b1;
            stall_IFDE = 1'b1;
            Stall_MW   = 1'b1;
          end
        end
        TRAP_DRAIN: begin
          // Let MW retire while nothing new enters DE
          stall_pc   = 1'b1;
          flush_IFDE = 1'b1;
        end
        TRAP_ENTER: begin
          trap_take  = 1'b1;
          flush_IFDE = 1'b1;
          flush_MW   = 1'b1;
        end
        default: begin
          stall_pc = 1'b0;
        end
      endcase
    end
  end

  assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipeline_hazard_sequencer                                         |
// | Directed scenarios plus randomized traffic, every cycle compared    |
// | against a timeline reference model of the hazard sequencer.         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_pipeline_hazard_sequencer;
  import hazard_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_ENTER = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1DE = '0, rs2DE = '0, rdMW = '0;
  logic       reg_wrMW = 1'b0;
  logic [1:0] wb_selMW = WB_ALU;
  logic       br_takenDE = 1'b0, dmem_req = 1'b0, dmem_ack = 1'b0;
  logic       irq_pending = 1'b0, is_mretMW = 1'b0;
  logic       stall_pc, stall_IFDE, Stall_MW, flush_IFDE, flush_MW;
  logic [1:0] fwd_a, fwd_b, state_o;
  logic       trap_take, mem_fault;

  pipeline_hazard_sequencer #(.MEM_TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .rs1DE(rs1DE), .rs2DE(rs2DE), .rdMW(rdMW),
    .reg_wrMW(reg_wrMW), .wb_selMW(wb_selMW), .br_takenDE(br_takenDE),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .irq_pending(irq_pending),
    .is_mretMW(is_mretMW), .stall_pc(stall_pc), .stall_IFDE(stall_IFDE),
    .Stall_MW(Stall_MW), .flush_IFDE(flush_IFDE), .flush_MW(flush_MW),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .trap_take(trap_take),
    .mem_fault(mem_fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: where the pipeline is, how long it has waited, and
  // whether a branch seen during a wait still owes a flush
  int m_mode = M_RUN;
  int m_wait = 0;
  bit m_pend = 1'b0;

  // Event tallies observed at the sample point, used by directed scenarios
  int stall_seen, fault_seen, flush_if_seen, trap_seen;
  logic [1:0] s_fwd_a, s_fwd_b, s_state;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (!reg_wrMW || rdMW == 5'd0 || rdMW != rs) return FWD_RF;
    if (wb_selMW == WB_MEM || wb_selMW == WB_CSR) return FWD_WB;
    return FWD_ALU;
  endfunction

  task automatic idle();
    br_takenDE = 0; dmem_req = 0; dmem_ack = 0; irq_pending = 0; is_mretMW = 0;
    reg_wrMW = 0; rdMW = 0; rs1DE = 0; rs2DE = 0; wb_selMW = WB_ALU;
  endtask

  task automatic clear_tallies();
    stall_seen = 0; fault_seen = 0; flush_if_seen = 0; trap_seen = 0;
  endtask

  // One clock: sample and compare on the falling edge, advance the model on the rising edge
  task automatic tick();
    logic e_spc, e_sif, e_smw, e_fif, e_fmw, e_trap, e_fault;
    logic [1:0] e_a, e_b;
    int n_mode, n_wait;
    bit n_pend;
    @(negedge clk);
    {e_spc, e_sif, e_smw, e_fif, e_fmw, e_trap, e_fault} = '0;
    e_a = FWD_RF; e_b = FWD_RF;
    n_mode = m_mode; n_wait = m_wait; n_pend = m_pend;
    if (rst) begin
      n_mode = M_RUN; n_wait = 0; n_pend = 1'b0;
    end else begin
      e_a = ref_fwd(rs1DE);
      e_b = ref_fwd(rs2DE);
      if (m_mode == M_RUN) begin
        if (dmem_req && !dmem_ack) begin
          {e_spc, e_sif, e_smw} = 3'b111;
          n_mode = M_WAIT; n_wait = 1; n_pend = m_pend | br_takenDE;
        end else if (irq_pending) begin
          n_mode = M_DRAIN; n_pend = 1'b0;
        end else begin
          e_fif = is_mretMW | br_takenDE | m_pend;
          e_fmw = is_mretMW;
          n_pend = 1'b0;
        end
      end else if (m_mode == M_WAIT) begin
        n_pend = m_pend | br_takenDE;
        if (dmem_ack) n_mode = M_RUN;
        else if (m_wait == TIMEOUT) begin
          e_fault = 1'b1; e_fmw = 1'b1; n_mode = M_RUN;
        end else begin
          {e_spc, e_sif, e_smw} = 3'b111;
          n_wait = m_wait + 1;
        end
      end else if (m_mode == M_DRAIN) begin
        e_spc = 1'b1; e_fif = 1'b1; n_mode = M_ENTER;
      end else begin
        e_trap = 1'b1; e_fif = 1'b1; e_fmw = 1'b1; n_pend = 1'b0; n_mode = M_RUN;
      end
    end
    check_eq("state_o", state_o, m_mode);
    check_eq("stall_pc", stall_pc, e_spc);
    check_eq("stall_IFDE", stall_IFDE, e_sif);
    check_eq("Stall_MW", Stall_MW, e_smw);
    check_eq("flush_IFDE", flush_IFDE, e_fif);
    check_eq("flush_MW", flush_MW, e_fmw);
    check_eq("trap_take", trap_take, e_trap);
    check_eq("mem_fault", mem_fault, e_fault);
    check_eq("fwd_a", fwd_a, e_a);
    check_eq("fwd_b", fwd_b, e_b);
    if (stall_pc && stall_IFDE && Stall_MW) stall_seen++;
    if (mem_fault) fault_seen++;
    if (flush_IFDE) flush_if_seen++;
    if (trap_take) trap_seen++;
    s_fwd_a = fwd_a; s_fwd_b = fwd_b; s_state = state_o;
    @(posedge clk);
    m_mode = n_mode; m_wait = n_wait; m_pend = n_pend;
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    m_mode = M_RUN; m_wait = 0; m_pend = 1'b0;
    // Reset state, with a memory request present to show outputs stay quiet
    dmem_req = 1; irq_pending = 1;
    tick();
    idle();
    rst = 1'b0;

    // 1: forwarding from an ALU result, then rd = x0, then a load result
    rdMW = 5; reg_wrMW = 1; wb_selMW = WB_ALU; rs1DE = 5; rs2DE = 6;
    tick();
    check_eq("t1_fwd_a_alu", s_fwd_a, FWD_ALU);
    check_eq("t1_fwd_b_rf", s_fwd_b, FWD_RF);
    rdMW = 0; rs1DE = 0;
    tick();
    check_eq("t1_x0_fwd_a", s_fwd_a, FWD_RF);
    rdMW = 6; wb_selMW = WB_MEM;
    tick();
    check_eq("t1_fwd_b_wb", s_fwd_b, FWD_WB);
    idle();

    // 2: memory wait acked on the third cycle after the request
    clear_tallies();
    dmem_req = 1; tick(); tick();
    check_eq("t2_state_wait", s_state, M_WAIT);
    tick();
    dmem_ack = 1; tick();
    idle(); tick();
    check_eq("t2_stall_cycles", stall_seen, 3);

    // 3: memory wait that never completes
    clear_tallies();
    dmem_req = 1; tick();
    dmem_req = 0;
    for (int i = 0; i < TIMEOUT; i++) tick();
    check_eq("t3_fault_pulses", fault_seen, 1);
    tick();
    check_eq("t3_state_run", s_state, M_RUN);
    check_eq("t3_fault_once", fault_seen, 1);
    check_eq("t3_stall_cycles", stall_seen, TIMEOUT);

    // 4: taken branch during a wait flushes once, after the ack
    clear_tallies();
    dmem_req = 1; tick();
    dmem_req = 0; br_takenDE = 1; tick(); tick();
    br_takenDE = 0; dmem_ack = 1; tick();
    check_eq("t4_no_flush_in_wait", flush_if_seen, 0);
    dmem_ack = 0; tick(); tick();
    check_eq("t4_flush_once", flush_if_seen, 1);

    // 5: interrupt with a simultaneous taken branch
    clear_tallies();
    irq_pending = 1; br_takenDE = 1; tick();
    idle(); tick(); tick(); tick();
    check_eq("t5_trap_once", trap_seen, 1);
    check_eq("t5_flush_if_count", flush_if_seen, 2);
    check_eq("t5_back_to_run", s_state, M_RUN);

    // 6: reset taken in the middle of a wait
    dmem_req = 1; tick(); tick();
    rst = 1; tick();
    rst = 0; dmem_req = 0; tick();
    check_eq("t6_state_run", s_state, M_RUN);

    // Randomized traffic across all inputs
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(99) == 0);
      dmem_req    = ($urandom_range(3) == 0);
      dmem_ack    = ($urandom_range(1) == 0);
      br_takenDE  = ($urandom_range(3) == 0);
      irq_pending = ($urandom_range(15) == 0);
      is_mretMW   = ($urandom_range(7) == 0);
      reg_wrMW    = ($urandom_range(1) == 0);
      wb_selMW    = 2'($urandom_range(3));
      rdMW        = 5'($urandom_range(7));
      rs1DE       = 5'($urandom_range(7));
      rs2DE       = 5'($urandom_range(7));
      tick();
    end
    // Long unacked waits so the timeout path also sees random neighbours
    for (int j = 0; j < 3; j++) begin
      idle(); rst = 0;
      dmem_req = 1; tick();
      dmem_req = 0;
      for (int k = 0; k < TIMEOUT + 2; k++) begin
        br_takenDE  = ($urandom_range(3) == 0);
        irq_pending = ($urandom_range(7) == 0);
        rdMW = 5'($urandom_range(7)); rs1DE = 5'($urandom_range(7));
        reg_wrMW = 1'($urandom_range(1));
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
